hazard_control_unit: RTL and testbench

//  Pipeline sequencer for the 5-stage LEGv8 CPU; works alongside the forwarding logic.

---
 rtl/hazard_control_unit.sv | 90 +++++++++
 tb/tb_hazard_control_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: IF/ID/EX sequencing for load-use, taken-branch and slow-memory hazards
// Inputs : clk_i, reset_i (async, active-high), Decode read addresses/uses, Execute dest/load,
//          BrTaken_i, MemReq_i/MemReady_i from the Mem stage.
// Outputs: PcWrite_o, IfIdWrite_o, IfIdFlush_o, IdExBubble_o, PipeFreeze_o (combinational),
//          MemTimeout_o (sticky halt flag), StallCycles_o/FlushCount_o (saturating counters).
module hazard_control_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [4:0]       DecAa_i,
   input  logic [4:0]       DecAb_i,
   input  logic             DecUsesAa_i,
   input  logic             DecUsesAb_i,
   input  logic [4:0]       ExAw_i,
   input  logic             ExMemRead_i,
   input  logic             BrTaken_i,
   input  logic             MemReq_i,
   input  logic             MemReady_i,
   output logic             PcWrite_o,
   output logic             IfIdWrite_o,
   output logic             IfIdFlush_o,
   output logic             IdExBubble_o,
   output logic             PipeFreeze_o,
   output logic             MemTimeout_o,
   output logic [CNT_W-1:0] StallCycles_o,
   output logic [CNT_W-1:0] FlushCount_o
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;
   state_t state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic memstall, loaduse;
   // A dropped MemReq counts as completion, so only an outstanding request freezes.
   assign memstall = MemReq_i & ~MemReady_i;
   // XZR is never a real producer.
   assign loaduse = ExMemRead_i & (ExAw_i != 5'd31) &
                    ((DecUsesAa_i & (DecAa_i == ExAw_i)) | (DecUsesAb_i & (DecAb_i == ExAw_i)));
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      PcWrite_o    = 1'b1;
      IfIdWrite_o  = 1'b1;
      IfIdFlush_o  = 1'b0;
      IdExBubble_o = 1'b0;
      PipeFreeze_o = 1'b0;
      if (reset_i) begin
         PcWrite_o    = 1'b0;
         IfIdWrite_o  = 1'b0;
         IfIdFlush_o  = 1'b1;
         IdExBubble_o = 1'b1;
      end else if (state_q == HALTED) begin
         PcWrite_o    = 1'b0;
         IfIdWrite_o  = 1'b0;
         PipeFreeze_o = 1'b1;
      end else if (memstall) begin
         PcWrite_o    = 1'b0;
         IfIdWrite_o  = 1'b0;
         PipeFreeze_o = 1'b1;
         wait_d       = (state_q == RUN) ? WW'(1) : wait_q + WW'(1);
         state_d      = (wait_d == WW'(MEM_TIMEOUT)) ? HALTED : MEM_WAIT;
      end else begin
         // Ready cycle of MEM_WAIT decodes exactly like RUN; a branch under a load-use stall is dropped.
         state_d      = RUN;
         wait_d       = '0;
         PcWrite_o    = ~loaduse;
         IfIdWrite_o  = ~loaduse;
         IdExBubble_o = loaduse;
         IfIdFlush_o  = ~loaduse & BrTaken_i;
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (!PcWrite_o && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (IfIdFlush_o && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end
   assign MemTimeout_o  = (state_q == HALTED);
   assign StallCycles_o = stall_q;
   assign FlushCount_o  = flush_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench with directed and random stimulus against a behavioural model
module tb_hazard_control_unit;
   localparam int TO = 8;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] aa = '0, ab = '0, aw = '0;
   logic ua = 1'b0, ub = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
   logic pc, ifw, fl, bu, fr, to;
   logic [CW-1:0] st, fc;
   always #5 clk = ~clk;
   hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .reset_i(reset),
      .DecAa_i(aa), .DecAb_i(ab), .DecUsesAa_i(ua), .DecUsesAb_i(ub),
      .ExAw_i(aw), .ExMemRead_i(mr), .BrTaken_i(br),
      .MemReq_i(req), .MemReady_i(rdy),
      .PcWrite_o(pc), .IfIdWrite_o(ifw), .IfIdFlush_o(fl), .IdExBubble_o(bu),
      .PipeFreeze_o(fr), .MemTimeout_o(to), .StallCycles_o(st), .FlushCount_o(fc)
   );
   typedef struct packed {
      logic pc, ifw, fl, bu, fr, to;
      logic [CW-1:0] st, fc;
   } exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0;
   int m_frozen = 0, m_st = 0, m_fc = 0;
   bit m_halt = 0;
   int smax = (1 << CW) - 1;
   task automatic step(input bit r, input bit [4:0] a, input bit [4:0] b, input bit [4:0] w,
                       input bit u_a, input bit u_b, input bit m, input bit bt,
                       input bit rq, input bit rd);
      exp_t e;
      bit lu;
      @(posedge clk);
      #1;
      reset = r; aa = a; ab = b; aw = w; ua = u_a; ub = u_b; mr = m; br = bt; req = rq; rdy = rd;
      lu = m && (w != 5'd31) && ((u_a && a == w) || (u_b && b == w));
      e = '0;
      e.pc = 1; e.ifw = 1; e.to = m_halt; e.st = CW'(m_st); e.fc = CW'(m_fc);
      if (r) begin
         e.pc = 0; e.ifw = 0; e.fl = 1; e.bu = 1; e.to = 0; e.st = 0; e.fc = 0;
         m_frozen = 0; m_halt = 0; m_st = 0; m_fc = 0;
      end else begin
         if (m_halt) begin
            e.pc = 0; e.ifw = 0; e.fr = 1;
         end else if (rq && !rd) begin
            e.pc = 0; e.ifw = 0; e.fr = 1;
            m_frozen++;
            if (m_frozen == TO) m_halt = 1;
         end else begin
            m_frozen = 0;
            if (lu) begin
               e.pc = 0; e.ifw = 0; e.bu = 1;
            end else if (bt) e.fl = 1;
         end
         if (!e.pc && m_st < smax) m_st++;
         if (e.fl && m_fc < smax) m_fc++;
      end
      q.push_back(e);
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   function automatic bit [4:0] pick();
      int v = $urandom_range(4);
      return (v == 4) ? 5'd31 : 5'(v);
   endfunction
   exp_t got, ex;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         ex = q.pop_front();
         got = {pc, ifw, fl, bu, fr, to, st, fc};
         vectors++;
         if (got !== ex)
            $display("FAIL vec%0d outputs pc/ifw/fl/bu/fr/to=%b%b%b%b%b%b st=%0d fc=%0d, need %b%b%b%b%b%b st=%0d fc=%0d",
                     vectors, got.pc, got.ifw, got.fl, got.bu, got.fr, got.to, got.st, got.fc,
                     ex.pc, ex.ifw, ex.fl, ex.bu, ex.fr, ex.to, ex.st, ex.fc);
         if (got !== ex) miscompares++;
      end
   end
   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step(0, 3, 0, 3, 1, 0, 1, 0, 0, 0);
      idle();
      step(0, 31, 0, 31, 1, 0, 1, 0, 0, 0);
      step(0, 0, 5, 5, 0, 1, 1, 0, 0, 0);
      step(0, 0, 5, 5, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 3, 0, 3, 1, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 2, 0, 2, 1, 0, 1, 1, 0, 0);
      repeat (TO + 2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      repeat (20) begin
         step(0, 7, 0, 7, 1, 0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      idle();
      for (int i = 0; i < 1500; i++)
         step($urandom_range(99) == 0, pick(), pick(), pick(), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(3) == 0, 1'($urandom));
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         $display("FAIL drain: %0d expected responses never checked, need 0", q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
